// File: rtl/io_ctrl_if.sv
// Register bus between a host and io_ctrl: word address, write strobe, write data,
// registered read data and the level interrupt.
interface io_ctrl_if;
  logic [4:0]  addr;
  logic [31:0] data_in;
  logic        write_enable;
  logic [31:0] data_out;
  logic        irq;

  modport master (
    output addr,
    output data_in,
    output write_enable,
    input  data_out,
    input  irq
  );

  modport slave (
    input  addr,
    input  data_in,
    input  write_enable,
    output data_out,
    output irq
  );
endinterface

// File: rtl/io_ctrl.sv
// Board I/O controller: paired 7-segment decimal display, blinking LEDs and debounced
// switches with sticky change flags and a maskable level interrupt.
module io_ctrl #(
  parameter int unsigned NUM_HEX      = 6,
  parameter int unsigned LED_W        = 10,
  parameter int unsigned SW_W         = 10,
  parameter int unsigned DEBOUNCE_CYC = 16,
  parameter int unsigned BLINK_DIV    = 25000000
) (
  input  logic                   clock,
  input  logic                   reset,
  io_ctrl_if.slave               bus,
  input  logic [SW_W-1:0]        io_in_sw,
  output logic [LED_W-1:0]       io_out_led,
  output logic [7*NUM_HEX-1:0]   io_out_hex
);

  localparam int unsigned NumPairs = NUM_HEX / 2;
  localparam int unsigned CntW     = $clog2(DEBOUNCE_CYC);
  localparam int unsigned PreW     = $clog2(BLINK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYC - 1);
  localparam logic [PreW-1:0] PreMax = PreW'(BLINK_DIV - 1);

  localparam logic [4:0] AddrLed     = 5'd8;
  localparam logic [4:0] AddrBlink   = 5'd9;
  localparam logic [4:0] AddrSwState = 5'd10;
  localparam logic [4:0] AddrSwChg   = 5'd11;
  localparam logic [4:0] AddrIrqEn   = 5'd12;

  // Active-low gfedcba; bit 0 is segment a.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // {tens, ones} segment pair; values of 100 and above blank both digits.
  function automatic logic [13:0] hex_pair(input logic [6:0] v);
    if (v >= 7'd100) return 14'h3FFF;
    return {seg7(4'(v / 7'd10)), seg7(4'(v % 7'd10))};
  endfunction

  logic [6:0]         hex_q     [NumPairs];
  logic [6:0]         hex_d     [NumPairs];
  logic [LED_W-1:0]   led_q, led_d, blink_q, blink_d;
  logic [SW_W-1:0]    irqen_q, irqen_d, swchg_q, swchg_d, swstate_q, swstate_d;
  logic [SW_W-1:0]    sync1_q, sync2_q, toggle, swchg_clr;
  logic [CntW-1:0]    cnt_q     [SW_W];
  logic [CntW-1:0]    cnt_d     [SW_W];
  logic [PreW-1:0]    presc_q, presc_d;
  logic               phase_q, phase_d;
  logic [31:0]        data_out_q, rdata;
  logic               irq_q;
  logic [LED_W-1:0]   led_out_q, led_out_d;
  logic [7*NUM_HEX-1:0] hex_out_q, hex_out_d;
  logic               unused_data_in;

  assign unused_data_in = ^bus.data_in;

  always_comb begin
    for (int k = 0; k < NumPairs; k++) begin
      hex_d[k] = hex_q[k];
      if (bus.write_enable && bus.addr == 5'(k)) hex_d[k] = bus.data_in[6:0];
    end
    led_d   = (bus.write_enable && bus.addr == AddrLed)   ? bus.data_in[LED_W-1:0] : led_q;
    blink_d = (bus.write_enable && bus.addr == AddrBlink) ? bus.data_in[LED_W-1:0] : blink_q;
    irqen_d = (bus.write_enable && bus.addr == AddrIrqEn) ? bus.data_in[SW_W-1:0]  : irqen_q;
    swchg_clr = (bus.write_enable && bus.addr == AddrSwChg) ? bus.data_in[SW_W-1:0] : '0;

    for (int i = 0; i < SW_W; i++) begin
      toggle[i] = 1'b0;
      if (sync2_q[i] == swstate_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntMax) begin
        cnt_d[i]  = '0;
        toggle[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
    swstate_d = swstate_q ^ toggle;
    // A debounce toggle wins over a same-cycle write-1-to-clear.
    swchg_d   = (swchg_q & ~swchg_clr) | toggle;

    presc_d = (presc_q == PreMax) ? '0 : presc_q + PreW'(1);
    phase_d = (presc_q == PreMax) ? ~phase_q : phase_q;

    case (bus.addr)
      AddrLed:     rdata = 32'(led_q);
      AddrBlink:   rdata = 32'(blink_q);
      AddrSwState: rdata = 32'(swstate_q);
      AddrSwChg:   rdata = 32'(swchg_q);
      AddrIrqEn:   rdata = 32'(irqen_q);
      default:     rdata = '0;
    endcase
    for (int k = 0; k < NumPairs; k++) begin
      if (bus.addr == 5'(k)) rdata = 32'(hex_q[k]);
    end

    led_out_d = led_q & ~(blink_q & {LED_W{phase_q}});
    for (int k = 0; k < NumPairs; k++) begin
      hex_out_d[14*k +: 14] = hex_pair(hex_q[k]);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NumPairs; k++) hex_q[k] <= 7'h7F;
      for (int i = 0; i < SW_W; i++) cnt_q[i] <= '0;
      led_q      <= '0;
      blink_q    <= '0;
      irqen_q    <= '0;
      swchg_q    <= '0;
      swstate_q  <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      presc_q    <= '0;
      phase_q    <= 1'b0;
      data_out_q <= '0;
      irq_q      <= 1'b0;
      led_out_q  <= '0;
      hex_out_q  <= '1;
    end else begin
      for (int k = 0; k < NumPairs; k++) hex_q[k] <= hex_d[k];
      for (int i = 0; i < SW_W; i++) cnt_q[i] <= cnt_d[i];
      led_q      <= led_d;
      blink_q    <= blink_d;
      irqen_q    <= irqen_d;
      swchg_q    <= swchg_d;
      swstate_q  <= swstate_d;
      sync1_q    <= io_in_sw;
      sync2_q    <= sync1_q;
      presc_q    <= presc_d;
      phase_q    <= phase_d;
      data_out_q <= rdata;
      irq_q      <= |(swchg_q & irqen_q);
      led_out_q  <= led_out_d;
      hex_out_q  <= hex_out_d;
    end
  end

  assign bus.data_out = data_out_q;
  assign bus.irq      = irq_q;
  assign io_out_led   = led_out_q;
  assign io_out_hex   = hex_out_q;

endmodule

// File: tb/tb_io_ctrl.sv
// Directed bench for io_ctrl: stimulus queues expected outputs by due cycle and a
// negedge monitor pops and compares them.
module tb_io_ctrl;
  localparam int unsigned NumHex = 6;
  localparam int unsigned LedW   = 10;
  localparam int unsigned SwW    = 10;
  localparam int unsigned Deb    = 4;
  localparam int unsigned Blk    = 4;

  localparam int SelData = 0;
  localparam int SelLed  = 1;
  localparam int SelHex  = 2;
  localparam int SelIrq  = 3;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [SwW-1:0]        sw    = '0;
  logic [LedW-1:0]       led;
  logic [7*NumHex-1:0]   hex;

  io_ctrl_if bus ();

  io_ctrl #(
    .NUM_HEX      (NumHex),
    .LED_W        (LedW),
    .SW_W         (SwW),
    .DEBOUNCE_CYC (Deb),
    .BLINK_DIV    (Blk)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .io_in_sw   (sw),
    .io_out_led (led),
    .io_out_hex (hex)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    int          due;
    int          sel;
    logic [63:0] exp;
  } chk_t;

  chk_t        sb[$];
  int          cyc     = 0;
  int          rel_cyc = 0;
  int          total   = 0;
  int          bad     = 0;
  chk_t        mon_e;
  logic [63:0] act;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      case (mon_e.sel)
        SelData: act = 64'(bus.data_out);
        SelLed:  act = 64'(led);
        SelHex:  act = 64'(hex);
        default: act = 64'(bus.irq);
      endcase
      total++;
      if (mon_e.due != cyc) begin
        bad++;
        $display("FAIL %s: check missed at cycle %0d (due %0d)", mon_e.name, cyc, mon_e.due);
      end else if (act !== mon_e.exp) begin
        bad++;
        $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", mon_e.name, act, mon_e.exp, cyc);
      end
    end
  end

  task automatic expect_v(input string nm, input int sel, input logic [63:0] e, input int dly);
    chk_t c;
    int   i;
    c.name = nm;
    c.due  = cyc + dly;
    c.sel  = sel;
    c.exp  = e;
    i = 0;
    while (i < sb.size() && sb[i].due <= c.due) i++;
    sb.insert(i, c);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.addr         = a;
    bus.data_in      = d;
    bus.write_enable = 1'b1;
    @(negedge clock);
    bus.write_enable = 1'b0;
    bus.data_in      = '0;
  endtask

  task automatic rd(input string nm, input logic [4:0] a, input logic [31:0] e);
    bus.addr = a;
    expect_v(nm, SelData, 64'(e), 1);
    @(negedge clock);
  endtask

  // Prescaler restarts at 0 on release; phase flips after posedges 4, 8, ... since then.
  task automatic check_blink(input int n);
    int k;
    int ph;
    for (int i = 1; i <= n; i++) begin
      k  = cyc + i - rel_cyc;
      ph = ((k - 1) / int'(Blk)) % 2;
      expect_v("blink_led", SelLed, (ph != 0) ? 64'h3FE : 64'h3FF, i);
    end
    step(n + 1);
  endtask

  initial begin
    bus.addr         = '0;
    bus.data_in      = '0;
    bus.write_enable = 1'b0;
    step(2);
    expect_v("rst_data_out", SelData, 64'h0, 1);
    expect_v("rst_led", SelLed, 64'h0, 1);
    expect_v("rst_hex", SelHex, 64'(42'h3FF_FFFF_FFFF), 1);
    expect_v("rst_irq", SelIrq, 64'h0, 1);
    step(1);
    reset   = 1'b0;
    rel_cyc = cyc;

    rd("rst_hex0", 5'd0, 32'h7F);
    rd("rst_led_reg", 5'd8, 32'h0);
    rd("rst_blink", 5'd9, 32'h0);
    rd("rst_swstate", 5'd10, 32'h0);
    rd("rst_swchg", 5'd11, 32'h0);
    rd("rst_irqen", 5'd12, 32'h0);

    // Decimal display: 42 -> "4","2"; 7 -> "0","7"; 99; 100 blanks; upper data bits ignored.
    wr(5'd0, 32'd42);
    expect_v("hex_42", SelHex, 64'({28'hFFF_FFFF, 7'h19, 7'h24}), 1);
    step(1);
    wr(5'd1, 32'd7);
    wr(5'd2, 32'd99);
    expect_v("hex_7_99", SelHex, 64'({7'h10, 7'h10, 7'h40, 7'h78, 7'h19, 7'h24}), 1);
    step(1);
    wr(5'd0, 32'd100);
    expect_v("hex_100", SelHex, 64'({7'h10, 7'h10, 7'h40, 7'h78, 7'h7F, 7'h7F}), 1);
    rd("hex0_100", 5'd0, 32'd100);
    wr(5'd0, 32'hABCD_EF85);
    rd("hex0_low7", 5'd0, 32'd5);
    expect_v("hex_5", SelHex, 64'({7'h10, 7'h10, 7'h40, 7'h78, 7'h40, 7'h12}), 1);
    step(1);

    // Read and write of LED in the same cycle returns the old value.
    bus.addr         = 5'd8;
    bus.data_in      = 32'hFFFF_F155;
    bus.write_enable = 1'b1;
    expect_v("rw_same_cycle", SelData, 64'h0, 1);
    step(1);
    bus.write_enable = 1'b0;
    rd("led_reg", 5'd8, 32'h155);
    expect_v("led_steady", SelLed, 64'h155, 1);
    step(1);

    wr(5'd8, 32'h3FF);
    wr(5'd9, 32'h001);
    step(2);
    check_blink(12);

    // Clean rise on sw[3]: SWSTATE visible exactly Deb+2 cycles after the edge.
    wr(5'd12, 32'h8);
    bus.addr = 5'd10;
    sw[3]    = 1'b1;
    expect_v("sw3_before", SelData, 64'h0, Deb + 2);
    expect_v("irq_before", SelIrq, 64'h0, Deb + 2);
    expect_v("sw3_after", SelData, 64'h8, Deb + 3);
    expect_v("irq_after", SelIrq, 64'h1, Deb + 3);
    step(Deb + 4);
    rd("swchg_set", 5'd11, 32'h8);
    wr(5'd11, 32'h8);
    expect_v("irq_cleared", SelIrq, 64'h0, 1);
    rd("swchg_w1c", 5'd11, 32'h0);

    // Glitch one sample short of the debounce window must be ignored.
    bus.addr = 5'd10;
    sw[0]    = 1'b1;
    step(Deb - 1);
    sw[0] = 1'b0;
    step(10);
    rd("glitch_swstate", 5'd10, 32'h8);
    rd("glitch_swchg", 5'd11, 32'h0);

    // Falling sw[3] toggles in the same cycle as a W1C of SWCHG[3]: flag stays set.
    sw[3] = 1'b0;
    step(Deb + 1);
    bus.addr         = 5'd11;
    bus.data_in      = 32'h8;
    bus.write_enable = 1'b1;
    step(1);
    bus.write_enable = 1'b0;
    rd("swchg_set_wins", 5'd11, 32'h8);
    rd("swstate_fell", 5'd10, 32'h0);
    expect_v("irq_set_wins", SelIrq, 64'h1, 1);
    step(1);
    wr(5'd11, 32'h8);
    expect_v("irq_cleared2", SelIrq, 64'h0, 1);
    step(1);

    // Unmapped and read-only addresses.
    wr(5'd20, 32'hFFFF_FFFF);
    wr(5'd10, 32'h3FF);
    rd("addr20", 5'd20, 32'h0);
    rd("addr13", 5'd13, 32'h0);
    rd("addr3", 5'd3, 32'h0);
    rd("keep_hex0", 5'd0, 32'd5);
    rd("keep_hex1", 5'd1, 32'd7);
    rd("keep_hex2", 5'd2, 32'd99);
    rd("keep_led", 5'd8, 32'h3FF);
    rd("keep_blink", 5'd9, 32'h1);
    rd("keep_swstate", 5'd10, 32'h0);
    rd("keep_swchg", 5'd11, 32'h0);
    rd("keep_irqen", 5'd12, 32'h8);

    // Reset mid-debounce with sw[5] held; it reappears Deb+2 cycles after release.
    sw[5] = 1'b1;
    step(2);
    reset = 1'b1;
    step(2);
    expect_v("rst2_data_out", SelData, 64'h0, 1);
    expect_v("rst2_led", SelLed, 64'h0, 1);
    expect_v("rst2_hex", SelHex, 64'(42'h3FF_FFFF_FFFF), 1);
    expect_v("rst2_irq", SelIrq, 64'h0, 1);
    step(1);
    bus.addr = 5'd10;
    reset    = 1'b0;
    rel_cyc  = cyc;
    expect_v("sw5_before", SelData, 64'h0, Deb + 2);
    expect_v("sw5_after", SelData, 64'h20, Deb + 3);
    step(Deb + 4);
    rd("sw5_swchg", 5'd11, 32'h20);
    rd("rst2_irqen", 5'd12, 32'h0);
    rd("rst2_led_reg", 5'd8, 32'h0);
    rd("rst2_hex0", 5'd0, 32'h7F);
    expect_v("rst2_irq_after", SelIrq, 64'h0, 1);
    expect_v("rst2_led_after", SelLed, 64'h0, 1);
    step(3);

    while (sb.size() != 0) begin
      mon_e = sb.pop_front();
      total++;
      bad++;
      $display("FAIL %s: never checked (due %0d, now %0d)", mon_e.name, mon_e.due, cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d want under 10000", cyc);
    $fatal(1);
  end

endmodule
